// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and constants: word/address types, well-known opcodes
// and the default instruction ROM image.
package cpu_pkg;

  localparam int INST_WIDTH = 32;

  typedef logic [INST_WIDTH-1:0] word_t;
  typedef logic [31:0]           addr_t;

  localparam word_t HALT_CODE = 32'hFFFF_FFFF;
  localparam word_t NOP_CODE  = 32'h0000_0000;

  // Words beyond the image are filled with NOP_CODE by the ROM.
  localparam int IMAGE_LEN = 8;
  localparam logic [IMAGE_LEN-1:0][INST_WIDTH-1:0] DEFAULT_ROM_IMAGE = {
    32'h0232_9006,
    32'h020F_8827,
    32'h01AE_7826,
    32'h014B_602A,
    32'h0109_5025,
    32'h00C7_2024,
    32'h00A4_1822,
    32'h0043_0820
  };

endpackage

// File: rtl/inst_rom.sv
// Constant, read-only instruction ROM with a purely combinational read port.
// PATCH_INDEX/PATCH_WORD optionally replace one word of the default image.
module inst_rom
  import cpu_pkg::*;
#(
  parameter int    ROM_DEPTH   = 64,
  parameter int    ADDR_W      = $clog2(ROM_DEPTH),
  parameter int    PATCH_INDEX = -1,
  parameter word_t PATCH_WORD  = NOP_CODE
) (
  input  logic [ADDR_W-1:0] i_index,
  output word_t             o_word
);

  word_t w_rom [ROM_DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < ROM_DEPTH; gi++) begin : g_word
      if (gi == PATCH_INDEX) begin : g_patch
        assign w_rom[gi] = PATCH_WORD;
      end else if (gi < IMAGE_LEN) begin : g_image
        assign w_rom[gi] = DEFAULT_ROM_IMAGE[gi];
      end else begin : g_fill
        assign w_rom[gi] = NOP_CODE;
      end
    end
  endgenerate

  assign o_word = w_rom[i_index];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: PC register plus combinational ROM lookup.
// Optional HALT freeze on 32'hFFFF_FFFF is enabled by defining INST_FETCH_HALT_EN.
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter int    ROM_DEPTH   = 64,
  parameter addr_t RESET_PC    = 32'h0000_0000,
  parameter int    PC_STEP     = 4,
  parameter int    PATCH_INDEX = -1,
  parameter word_t PATCH_WORD  = NOP_CODE
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic [31:0] Inst_Code,
  output logic [31:0] PC
);

  localparam int ADDR_W = $clog2(ROM_DEPTH);

  // Initialiser gives a valid PC even if Rst is never asserted.
  addr_t r_pc = RESET_PC;
  logic  w_halt;
  word_t w_inst;

  // Upper PC bits are dropped, so fetch aliases and wraps through the ROM.
  inst_rom #(
    .ROM_DEPTH  (ROM_DEPTH),
    .ADDR_W     (ADDR_W),
    .PATCH_INDEX(PATCH_INDEX),
    .PATCH_WORD (PATCH_WORD)
  ) u_rom (
    .i_index(r_pc[ADDR_W+1:2]),
    .o_word (w_inst)
  );

`ifdef INST_FETCH_HALT_EN
  assign w_halt = (w_inst == HALT_CODE);
`else
  assign w_halt = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_pc <= RESET_PC;
    end else if (!w_halt) begin
      r_pc <= r_pc + addr_t'(PC_STEP);
    end
  end

  assign PC        = r_pc;
  assign Inst_Code = w_inst;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit (default image plus a
// second instance with word 3 patched to the HALT marker).
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst_code;
  logic [31:0] pc;
  logic [31:0] h_inst_code;
  logic [31:0] h_pc;

  int tests_run    = 0;
  int tests_failed = 0;

  inst_fetch_unit u_dut (
    .Clk      (clk),
    .Rst      (rst),
    .Inst_Code(inst_code),
    .PC       (pc)
  );

  inst_fetch_unit #(
    .PATCH_INDEX(3),
    .PATCH_WORD (32'hFFFF_FFFF)
  ) u_dut_halt (
    .Clk      (clk),
    .Rst      (rst),
    .Inst_Code(h_inst_code),
    .PC       (h_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, got);
    end
  endtask

  // One full clock: rising edge, falling edge, then settle 1 time unit after.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      #4 clk = 1'b1;
      #5 clk = 1'b0;
      #1;
    end
  endtask

  initial begin
    #1;
    check("powerup_pc",   pc,        32'h0000_0000);
    check("powerup_inst", inst_code, 32'h0043_0820);
    check("powerup_halt_pc", h_pc,   32'h0000_0000);

    tick(1);
    check("edge1_pc",   pc,        32'h0000_0004);
    check("edge1_inst", inst_code, 32'h00A4_1822);
    tick(1);
    check("edge2_pc",   pc,        32'h0000_0008);
    check("edge2_inst", inst_code, 32'h00C7_2024);

    rst = 1'b1; tick(1); rst = 1'b0;
    check("reset_pc",   pc,        32'h0000_0000);
    check("reset_inst", inst_code, 32'h0043_0820);

    tick(7);
    check("edge7_inst", inst_code, 32'h0232_9006);
    tick(1);
    check("edge8_pc",   pc,        32'h0000_0020);
    check("edge8_inst", inst_code, 32'h0000_0000);
    tick(55);
    check("edge63_pc",   pc,        32'h0000_00FC);
    check("edge63_inst", inst_code, 32'h0000_0000);
    tick(1);
    check("wrap_pc",   pc,        32'h0000_0100);
    check("wrap_inst", inst_code, 32'h0043_0820);
    tick(1);
    check("wrap1_inst", inst_code, 32'h00A4_1822);

    rst = 1'b1; tick(1); rst = 1'b0;
    tick(5);
    check("run5_pc",   pc,        32'h0000_0014);
    check("run5_inst", inst_code, 32'h01AE_7826);
    rst = 1'b1; tick(1);
    check("midrst_pc",   pc,        32'h0000_0000);
    check("midrst_inst", inst_code, 32'h0043_0820);
    tick(1);
    check("hold2_pc", pc, 32'h0000_0000);
    tick(1);
    check("hold3_pc", pc, 32'h0000_0000);
    rst = 1'b0;

    tick(1);
    check("post_hold_pc", pc, 32'h0000_0004);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pc", pc, 32'h0000_0004);
    tick(1);
    check("sync_rst_pc", pc, 32'h0000_0000);
    rst = 1'b0;

    // Patched instance: word 3 is the HALT marker.
    rst = 1'b1; tick(1); rst = 1'b0;
    tick(3);
    check("halt_reach_pc",   h_pc,        32'h0000_000C);
    check("halt_reach_inst", h_inst_code, 32'hFFFF_FFFF);
`ifdef INST_FETCH_HALT_EN
    tick(10);
    check("halt_frozen_pc", h_pc, 32'h0000_000C);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("halt_rst_pc", h_pc, 32'h0000_0000);
    tick(1);
    check("halt_resume_pc", h_pc, 32'h0000_0004);
`else
    tick(1);
    check("nohalt_pc",   h_pc,        32'h0000_0010);
    check("nohalt_inst", h_inst_code, 32'h014B_602A);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch stage of the single-cycle CPU datapath.
- Holds the program counter (PC) and a word-organised instruction ROM.
- Each rising clock edge advances PC by one instruction.
- The instruction at the current PC is presented combinationally to the decode stage (Inst_Code) together with PC.

Parameters:
- ROM_DEPTH, 64, number of 32-bit instruction words in ROM (power of two, 4..1024)
- RESET_PC, 32'h0000_0000, PC value after reset and at power-up (word aligned)
- PC_STEP, 4, byte increment applied to PC per cycle

Ports:
- Clk  input  1  system clock, rising-edge active
- Rst  input  1  synchronous active-high reset
- Inst_Code  output  32  instruction word addressed by PC
- PC  output  32  current program counter (byte address)

Behaviour:
- Interface: one clock (Clk); reset (Rst) is synchronous and active-high.
- PC register:
  - Powers up to RESET_PC; the register has an initial value, so the block runs correctly even if Rst is never asserted.
  - On a rising Clk edge with Rst=1: PC <= RESET_PC.
  - On a rising Clk edge otherwise: PC <= PC + PC_STEP, modulo 2^32.
  - PC changes only on rising edges. Falling edges and level changes have no effect.
- ROM address:
  - Word index = PC[log2(ROM_DEPTH)+1 : 2].
  - PC[1:0] is ignored.
  - Upper PC bits are ignored, so the ROM aliases and fetch wraps from the last word back to word 0 (e.g. PC=0x100 with depth 64 fetches word 0).
- ROM read: Inst_Code = ROM[index], purely combinational, zero-cycle latency from PC. A new PC and its instruction are valid in the same cycle.
- ROM contents are a constant image, read-only, with no write port. Default image, word: value:
  - 0: 32'h0043_0820
  - 1: 32'h00A4_1822
  - 2: 32'h00C7_2024
  - 3: 32'h0109_5025
  - 4: 32'h014B_602A
  - 5: 32'h01AE_7826
  - 6: 32'h020F_8827
  - 7: 32'h0232_9006
  - 8..ROM_DEPTH-1: 32'h0000_0000 (NOP)
- Reset values: PC=RESET_PC; Inst_Code=ROM[RESET_PC index] (32'h0043_0820 for defaults).
- Reset held for several cycles: PC stays at RESET_PC.
- Reset asserted mid-run: PC returns to RESET_PC on that edge.
- Rst takes priority over the increment (and over halt, if present).

Optional Feature:
- Macro INST_FETCH_HALT_EN.
- Defined:
  - When Inst_Code == 32'hFFFF_FFFF (HALT marker), PC holds its value on subsequent edges instead of incrementing.
  - Fetch stays frozen until Rst=1, which reloads RESET_PC.
- Undefined: 32'hFFFF_FFFF is an ordinary word and PC always increments.

Decomposition:
- Shared package (cpu_pkg) holds:
  - word and address typedefs
  - INST_WIDTH=32
  - HALT_CODE=32'hFFFF_FFFF
  - NOP_CODE=32'h0
  - the default ROM image constant
- One natural sub-module: inst_rom (combinational ROM, index in, 32-bit word out).
- inst_fetch_unit keeps the PC register and the increment/halt logic.

Test Plan:
- Power-up, no reset, no edges -> PC=0x0, Inst_Code=0x00430820.
- Rst=0, first rising edge -> PC=0x4, Inst_Code=0x00A41822; after a falling edge and a second rising edge -> PC=0x8, Inst_Code=0x00C72024.
- 8 rising edges from reset -> PC=0x20, Inst_Code=0x00000000; after 64 edges -> PC=0x100, Inst_Code=0x00430820 (wrap).
- Run 5 edges (PC=0x14), assert Rst for 1 edge -> PC=0x0, Inst_Code=0x00430820; hold Rst 3 edges -> PC stays 0x0.
- Rst asserted between edges (not on an edge) -> PC unchanged until the next rising edge.
- INST_FETCH_HALT_EN with word 3 = 0xFFFFFFFF -> PC reaches 0xC and stays 0xC over 10 further edges; Rst -> PC=0x0, then increments again.
